// File: rtl/ps2_frame_receiver.sv
// rtl/ps2_frame_receiver.sv - PS/2 device-to-host frame receiver with byte FIFO
// Deserialises start/8 data/odd parity/stop frames sampled on ps2_clk falling edges.
module ps2_frame_receiver #(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        clk_sync_q;
    logic [1:0]        data_sync_q;
    logic [3:0]        cnt_q, cnt_d;
    logic [9:0]        shift_q, shift_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic              push_q, push_d;
    logic [7:0]        push_byte_q, push_byte_d;
    logic              frame_err_q, frame_err_d;
    logic [FIFO_AW:0]  wp_q, wp_d;
    logic [FIFO_AW:0]  rp_q, rp_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        mem [DEPTH];

    logic fall;
    logic sample;
    logic frame_ok;
    logic empty;
    logic full;
    logic pop;
    logic wr_en;

    assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
    assign sample = data_sync_q[1];
    // shift_q holds start at [0], data at [8:1], parity at [9]; the stop bit is the live sample
    assign frame_ok = ~shift_q[0] & sample & (^shift_q[9:1]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        to_cnt_d    = to_cnt_q;
        push_d      = 1'b0;
        push_byte_d = push_byte_q;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                to_cnt_d = '0;
                if (fall) begin
                    shift_d[0] = sample;
                    cnt_d      = 4'd1;
                    state_d    = ST_RECV;
                end
            end
            ST_RECV: begin
                if (fall) begin
                    to_cnt_d = '0;
                    if (cnt_q == 4'd10) begin
                        cnt_d   = 4'd0;
                        state_d = ST_IDLE;
                        if (frame_ok) begin
                            push_d      = 1'b1;
                            push_byte_d = shift_q[8:1];
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        shift_d[cnt_q] = sample;
                        cnt_d          = cnt_q + 4'd1;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    to_cnt_d = '0;
                    cnt_d    = 4'd0;
                    state_d  = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) &&
                   (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
    assign pop   = ~nextdata_n & ~empty;
    assign wr_en = push_q & ~full;

    // Fullness is judged before this cycle's pop, so a drop wins over a coincident pop
    always_comb begin
        wp_d       = wr_en ? wp_q + 1'b1 : wp_q;
        rp_d       = pop ? rp_q + 1'b1 : rp_q;
        overflow_d = overflow_q;
        if (push_q && full) begin
            overflow_d = 1'b1;
        end else if (pop) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= ST_IDLE;
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
            cnt_q       <= 4'd0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            push_q      <= 1'b0;
            push_byte_q <= 8'h00;
            frame_err_q <= 1'b0;
            wp_q        <= '0;
            rp_q        <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            push_q      <= push_d;
            push_byte_q <= push_byte_d;
            frame_err_q <= frame_err_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp_q[FIFO_AW-1:0]] <= push_byte_q;
        end
    end

    assign data      = mem[rp_q[FIFO_AW-1:0]];
    assign ready     = ~empty;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule
